// File: rtl/serial_adder_pkg.sv
// Shared definitions for the slice-serial adder: FSM state encoding,
// default operand/slice widths and the slice-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_SLICE = 4;

    // Slice counter must hold 0..n-1 but never collapse to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_add_slice.sv
// Combinational SLICE-bit ripple adder. Besides the sum and carry-out it
// exposes the carry into its MSB so the caller can form signed overflow.
module add_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             cm
);

    logic c;

    // Ripple the carry from LSB to MSB, capturing the carry entering the MSB.
    // NOTE: blocking assignments here are intentional; c must carry its
    // updated value from one loop iteration to the next within the same pass.
    always_comb begin
        s  = '0;
        cm = 1'b0;
        c  = ci;
        for (int i = 0; i < SLICE; i++) begin
            if (i == SLICE - 1) cm = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_adder.sv
// Slice-serial adder: accepts WIDTH-bit operands, adds SLICE bits per cycle
// (LSB slice first) and presents sum/cout/ovf after WIDTH/SLICE cycles with
// a valid/ready handshake on both sides.
// Optional feature: define SERIAL_ADDER_SUB_EN to add the sub port
// (a - b via ~b and forced carry-in of 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SLICE = DEFAULT_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = cnt_width(N);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             cout_r;
    logic             ovf_r;

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic [SLICE-1:0] ss;
    logic             sco;
    logic             scm;

    assign sa = a_r[int'(cnt) * SLICE +: SLICE];
    assign sb = b_r[int'(cnt) * SLICE +: SLICE];

    add_slice #(.SLICE(SLICE)) u_slice (
        .a  (sa),
        .b  (sb),
        .ci (carry),
        .s  (ss),
        .co (sco),
        .cm (scm)
    );

    // Handshake flags are pure decodes of the registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Control FSM and datapath: latch operands, step one slice per cycle, hold result.
    // NOTE: state uses non-blocking assignments and an asynchronous reset;
    // the operand registers are reset too so nothing is ever X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
`ifdef SERIAL_ADDER_SUB_EN
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_r   <= b;
                        carry <= cin;
`endif
                        cnt   <= '0;
                        sum_r <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    sum_r[int'(cnt) * SLICE +: SLICE] <= ss;
                    carry <= sco;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        cout_r <= sco;
                        ovf_r  <= scm ^ sco;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=16, SLICE=4). A scoreboard
// predicts each accepted operation with plain integer arithmetic and checks
// every cycle the result is presented; directed cases pin literal values.
// Define SERIAL_ADDER_SUB_EN to exercise the subtract port.
module tb_serial_adder;

    localparam int W = 16;
    localparam int N = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc;
        bit           seen;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_vec = 0;
    int   n_err = 0;
    int   cycle = 0;
    exp_t q[$];
    int   acc_log[$];

    serial_adder #(.WIDTH(16), .SLICE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word integer addition (subtract = a + ~b + 1).
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t         r;
        logic [W-1:0] yy;
        logic         cc;
        logic [W:0]   full;
`ifdef SERIAL_ADDER_SUB_EN
        yy = s ? ~y : y;
        cc = s ? 1'b1 : c;
`else
        yy = y;
        cc = c;
`endif
        full   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        r.s    = full[W-1:0];
        r.c    = full[W];
        r.o    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        r.acc  = 0;
        r.seen = 1'b0;
        return r;
    endfunction

    // Acceptance monitor: inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && in_valid && in_ready) begin
            exp_t e;
            e     = model(a, b, cin, sub);
            e.acc = cycle + 1;
            q.push_back(e);
            acc_log.push_back(cycle + 1);
        end
    end

    // Compare process: every presented result is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("ready_valid_excl", 32'(in_ready && out_valid), 32'd0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", 32'd1, 32'd0);
                end else begin
                    if (!q[0].seen) begin
                        check("latency", 32'(cycle - q[0].acc), 32'(N));
                        q[0].seen = 1'b1;
                    end
                    check("sum",  32'(sum),  32'(q[0].s));
                    check("cout", 32'(cout), 32'(q[0].c));
                    check("ovf",  32'(ovf),  32'(q[0].o));
                    if (out_ready) void'(q.pop_front());
                end
            end else if (q.size() > 0 && !q[0].seen && (cycle - q[0].acc) > N + 2) begin
                check("result_timeout", 32'd1, 32'd0);
                void'(q.pop_front());
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                          input logic ts, input logic [W-1:0] es, input logic ec,
                          input logic eo, input string tag);
        bit got;
        int lat;
        @(posedge clk); #1;
        a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin got = 1'b1; break; end
        end
        check({tag, "_accept"}, 32'(got), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"},  32'(sum),  32'(es));
        check({tag, "_cout"}, 32'(cout), 32'(ec));
        check({tag, "_ovf"},  32'(ovf),  32'(eo));
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        check({tag, "_drain"}, 32'(q.size()), 32'd0);
    endtask

    task automatic wait_accepts(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (acc_log.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        exp_t         m;
        logic [W-1:0] held;
        bit           ok;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Pin the reference model to hand-computed values.
        m = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("model_pin_wrap", 32'({m.c, m.o, m.s}), 32'h20000);
        m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("model_pin_ovf", 32'({m.c, m.o, m.s}), 32'h18000);
        m = model(16'h00F0, 16'h0F0F, 1'b1, 1'b0);
        check("model_pin_cin", 32'({m.c, m.o, m.s}), 32'h01000);

        // Reset state.
        #3;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_cout",      32'(cout),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        #20 rst_n = 1'b1;

        // Directed boundary cases.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "wrap");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "sovf");
        run_op(16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, "cin");
`ifdef SERIAL_ADDER_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
`endif
        wait_drain("directed");

        // Back-pressure: result held while out_ready is low, no new accept.
        @(posedge clk); #1;
        a = 16'h1357; b = 16'h2468; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin ok = 1'b1; break; end
        end
        check("bp_result_seen", 32'(ok), 32'd1);
        held = sum;
        check("bp_sum_value", 32'(held), 32'h37BF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", 32'(in_ready),  32'd0);
            check("bp_held_valid",   32'(out_valid), 32'd1);
            check("bp_held_sum",     32'(sum),       32'(held));
        end
        @(posedge clk); #1;
        out_ready = 1'b1; a = 16'h0101; b = 16'h0202;
        @(posedge clk); #1;   // handshake edge
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_after_hs", 32'(in_ready),  32'd1);
        check("bp_valid_dropped", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp_reaccept", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain("backpressure");

        // Reset in the middle of BUSY (slice 2), then a clean operation.
        acc_log.delete();
        @(posedge clk); #1;
        a = 16'hABCD; b = 16'h1111; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        wait_accepts(1, ok);
        check("abort_accept", 32'(ok), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready",  32'(in_ready),  32'd1);
        check("abort_sum",       32'(sum),       32'd0);
        check("abort_cout",      32'(cout),      32'd0);
        check("abort_ovf",       32'(ovf),       32'd0);
        q.delete();
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", 32'(in_ready), 32'd1);
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "post_reset");
        wait_drain("post_reset");

        // Back-to-back throughput with both handshakes held high.
        acc_log.delete();
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            wait_accepts(i + 1, ok);
            check("b2b_accept", 32'(ok), 32'd1);
        end
        in_valid = 1'b0;
        wait_drain("b2b");
        if (acc_log.size() == 3) begin
            check("b2b_spacing_1", 32'(acc_log[1] - acc_log[0]), 32'(N + 2));
            check("b2b_spacing_2", 32'(acc_log[2] - acc_log[1]), 32'(N + 2));
        end else begin
            check("b2b_accept_count", 32'(acc_log.size()), 32'd3);
        end

        // Randomized traffic with random back-pressure.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        wait_drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
